// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: round-robin sharing of one byte-wide SRAM controller
// between NUM_REQ requesters, one transaction in flight at a time.
//
// state | meaning
// IDLE  | no transaction; scan requests starting after last_gnt
// ISSUE | one-cycle trigger to the controller, latency counter loaded
// WAIT  | count down access latency; read byte captured at zero
// RESP  | ack the winner, advance round-robin pointer
module sram_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int MEM_LAT = 3,
  parameter int PTR_W   = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [NUM_REQ-1:0]    req_in,
  input  logic [NUM_REQ-1:0]    rw_in,
  input  logic [NUM_REQ*19-1:0] addr_in,
  input  logic [NUM_REQ*8-1:0]  wdata_in,
  output logic [NUM_REQ-1:0]    gnt_out,
  output logic [NUM_REQ-1:0]    ack_out,
  output logic [7:0]            rdata_out,
  output logic                  busy_out,
  output logic                  mem_trig_out,
  output logic                  mem_rw_out,
  output logic [18:0]           mem_addr_out,
  output logic [7:0]            mem_wdata_out,
  input  logic [7:0]            mem_rdata_in
);

  // Requests are padded to the full pointer range so a PTR_W-bit index
  // always selects a defined bit; padded bits are constant zero.
  localparam int               NSLOT    = 1 << PTR_W;
  localparam logic [PTR_W-1:0] LAT_LOAD = PTR_W'(MEM_LAT - 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_last_gnt;
  logic [PTR_W-1:0]   r_winner;
  logic [PTR_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [7:0]         r_rdata;
  logic               r_mem_rw;
  logic [18:0]        r_mem_addr;
  logic [7:0]         r_mem_wdata;

  logic [NSLOT-1:0]   w_req_pad;
  logic               w_found;
  logic [PTR_W-1:0]   w_sel;
  logic [PTR_W-1:0]   w_scan_idx;
  logic [NUM_REQ-1:0] w_sel_onehot;
  logic               w_sel_rw;
  logic [18:0]        w_sel_addr;
  logic [7:0]         w_sel_wdata;
  logic               w_grant;

  assign w_req_pad = NSLOT'(req_in);

  // Round-robin scan: first requester at or after last_gnt+1, wrapping mod NUM_REQ.
  always_comb begin
    w_found    = 1'b0;
    w_sel      = '0;
    w_scan_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scan_idx = PTR_W'((int'(r_last_gnt) + k) % NUM_REQ);
      if (!w_found && w_req_pad[w_scan_idx]) begin
        w_found = 1'b1;
        w_sel   = w_scan_idx;
      end
    end
  end

  // Mux the selected requester's fields and build its one-hot grant.
  always_comb begin
    w_sel_onehot = '0;
    w_sel_rw     = 1'b0;
    w_sel_addr   = '0;
    w_sel_wdata  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == PTR_W'(i)) begin
        w_sel_onehot[i] = 1'b1;
        w_sel_rw        = rw_in[i];
        w_sel_addr      = addr_in[19*i +: 19];
        w_sel_wdata     = wdata_in[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    busy_out     = 1'b1;
    mem_trig_out = 1'b0;
    ack_out      = '0;
    case (r_state)
      IDLE: begin
        busy_out = 1'b0;
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_trig_out = 1'b1;
        w_state_nxt  = WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        ack_out     = r_gnt;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Transaction datapath: latch fields at grant, run latency counter,
  // capture read byte, advance pointer on completion.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_last_gnt  <= PTR_RST;
      r_winner    <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rdata     <= '0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_grant) begin
        r_winner    <= w_sel;
        r_gnt       <= w_sel_onehot;
        r_mem_rw    <= w_sel_rw;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
      if (r_state == ISSUE) begin
        r_cnt <= LAT_LOAD;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - PTR_W'(1);
      end
      if (r_state == WAIT && r_cnt == '0 && r_mem_rw) begin
        r_rdata <= mem_rdata_in;
      end
      if (r_state == RESP) begin
        r_gnt      <= '0;
        r_last_gnt <= r_winner;
      end
    end
  end

  assign gnt_out       = r_gnt;
  assign rdata_out     = r_rdata;
  assign mem_rw_out    = r_mem_rw;
  assign mem_addr_out  = r_mem_addr;
  assign mem_wdata_out = r_mem_wdata;

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Shares the single byte-wide SRAM controller between NUM_REQ requesters, e.g. the left/right image writers and the disparity-window reader.
- Round-robin arbitration; one transaction in flight at a time.
- Sequences the controller's one-cycle trigger, waits a fixed access latency, captures read data, then acknowledges the winning requester.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MEM_LAT, 3, cycles between controller trigger and valid read data / write completion (>=1).
- PTR_W, 2, width of grant pointer and counters; must satisfy 2^PTR_W >= max(NUM_REQ, MEM_LAT+1).

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous reset, active-high.
- req_in  input  NUM_REQ  per-requester request level.
- rw_in  input  NUM_REQ  per-requester direction, 1=read, 0=write.
- addr_in  input  NUM_REQ*19  per-requester byte address, requester i at [19i+18:19i].
- wdata_in  input  NUM_REQ*8  per-requester write byte, requester i at [8i+7:8i].
- gnt_out  output  NUM_REQ  one-hot grant, high for the whole transaction.
- ack_out  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata_out  output  8  shared read-data return, valid in the ack cycle and held until the next read ack.
- busy_out  output  1  high whenever state != IDLE.
- mem_trig_out  output  1  one-cycle trigger to the SRAM controller.
- mem_rw_out  output  1  direction to the controller.
- mem_addr_out  output  19  byte address to the controller.
- mem_wdata_out  output  8  write byte to the controller.
- mem_rdata_in  input  8  read byte from the controller.

Behaviour:
- Reset (async, rst_in=1): state=IDLE.
  - All outputs 0: gnt_out, ack_out, rdata_out, busy_out, mem_trig_out, mem_rw_out, mem_addr_out, mem_wdata_out.
  - Pointer last_gnt=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transaction abandons it; no ack is issued.
- Requester contract:
  - Assert req_in[i] with rw/addr/wdata stable until ack_out[i].
  - After ack it may drop req or keep it asserted for the next access.
  - Fields are latched at grant, so later changes are ignored.
- State machine:
  - IDLE: if |req_in, select the winner as the first set bit scanning from (last_gnt+1) mod NUM_REQ upward with wrap. Latch its rw/addr/wdata into mem_*_out, set gnt_out one-hot, go ISSUE. Otherwise stay in IDLE.
  - ISSUE: mem_trig_out=1 for exactly this cycle; load wait counter with MEM_LAT-1; go WAIT.
  - WAIT: counter decrements each cycle. When counter==0: if mem_rw_out=1, capture mem_rdata_in into rdata_out on that edge; go RESP.
  - RESP: ack_out[winner]=1 for this cycle; gnt_out cleared at the end of the cycle; last_gnt=winner; go IDLE.
- Latency: req seen in IDLE at cycle T.
  - mem_trig_out high at T+1.
  - ack at T+2+MEM_LAT (T+5 at default).
  - Back-to-back throughput: one access per MEM_LAT+3 cycles.
- Writes never modify rdata_out.
- mem_addr_out, mem_rw_out and mem_wdata_out hold their values from grant through RESP. They are not cleared in IDLE; they keep the last values.
- Requester drops req mid-transaction: the transaction still completes and ack is still pulsed.
- Simultaneous requests: exactly one grant; the others wait. No requester waits more than NUM_REQ-1 transactions once asserted.
- Only one bit of gnt_out/ack_out is ever high; ack_out is never high outside RESP.
- Only in-range indices are granted: bits at or above NUM_REQ are ignored in the scan; pointer wrap uses mod NUM_REQ, not 2^PTR_W.

Test Plan:
- Reset, then req_in=001, rw=1, addr0=0x00005, mem_rdata_in=0xA5 -> mem_trig_out high at cycle 1 only, mem_addr_out=0x00005, ack_out=001 at cycle 5, rdata_out=0xA5 held afterwards.
- req_in=111 held constantly, all writes with wdata0/1/2=0x11/0x22/0x33 -> grant order 0,1,2,0,1,2, mem_wdata_out matches the granted requester, acks 6 cycles apart.
- Last grant was 1, then req_in=101 -> requester 2 granted next, then 0.
- Write to 0x7FFFF, wdata=0xFF, mem_rdata_in=0x3C -> rdata_out unchanged from the previous read (0xA5); mem_rw_out=0 throughout.
- req0 drops during WAIT -> ack_out[0] still pulses at the scheduled cycle; the next grant follows the round-robin order.
- rst_in asserted during WAIT -> all outputs 0 immediately, no ack. After release, req_in=110 -> requester 1 granted first.
